// File: rtl/bidir_bus_port.sv
// Bidirectional bus sequencer: drives BB tristate I/T controls and wr_n/rd_n strobes with
// setup/strobe/hold/turnaround spacing. Define BIDIR_BUS_SYNC_EN to synchronize bus_o.
module bidir_bus_port #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETUP_CLOCKS  = 2,
  parameter int unsigned STROBE_CLOCKS = 2,
  parameter int unsigned HOLD_CLOCKS   = 1,
  parameter int unsigned TURN_CLOCKS   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] bus_i,
  output logic             bus_t,
  input  logic [WIDTH-1:0] bus_o,
  output logic             wr_n,
  output logic             rd_n
);

  logic [WIDTH-1:0] sampled;

`ifdef BIDIR_BUS_SYNC_EN
  localparam int unsigned SYNC_DEPTH = 2;

  logic [WIDTH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus_o;
      sync2_q <= sync1_q;
    end
  end

  assign sampled = sync2_q;
`else
  localparam int unsigned SYNC_DEPTH = 0;

  assign sampled = bus_o;
`endif

  localparam int unsigned READ_CLOCKS = STROBE_CLOCKS + SYNC_DEPTH;
  localparam int unsigned MAX_A   = (SETUP_CLOCKS > HOLD_CLOCKS) ? SETUP_CLOCKS : HOLD_CLOCKS;
  localparam int unsigned MAX_B   = (READ_CLOCKS > TURN_CLOCKS) ? READ_CLOCKS : TURN_CLOCKS;
  localparam int unsigned MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

  // Counter is loaded with (duration - 1) on state entry; the state ends when it reaches zero.
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CLOCKS - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CLOCKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CLOCKS - 1);
  localparam logic [CNT_W-1:0] READ_LOAD   = CNT_W'(READ_CLOCKS - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CLOCKS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWSetup,
    StWStrobe,
    StWHold,
    StRStrobe,
    StTurn
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] bus_i_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_valid_q;
  logic             cnt_done;
  logic             accept;
  logic             read_done;

  assign cnt_done  = (cnt_q == '0);
  assign accept    = req_valid && (state_q == StIdle);
  assign read_done = (state_q == StRStrobe) && cnt_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_done ? cnt_q : cnt_q - CNT_W'(1);
    unique case (state_q)
      StIdle: begin
        cnt_d = cnt_q;
        if (req_valid) begin
          if (req_write) begin
            state_d = StWSetup;
            cnt_d   = SETUP_LOAD;
          end else begin
            state_d = StRStrobe;
            cnt_d   = READ_LOAD;
          end
        end
      end
      StWSetup: begin
        if (cnt_done) begin
          state_d = StWStrobe;
          cnt_d   = STROBE_LOAD;
        end
      end
      StWStrobe: begin
        if (cnt_done) begin
          state_d = StWHold;
          cnt_d   = HOLD_LOAD;
        end
      end
      StWHold, StRStrobe: begin
        if (cnt_done) begin
          state_d = StTurn;
          cnt_d   = TURN_LOAD;
        end
      end
      StTurn: begin
        if (cnt_done) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // bus_i only changes on a write accept so it holds its value while tristated.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_i_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (accept && req_write) begin
        bus_i_q <= req_data;
      end
      if (read_done) begin
        rsp_data_q <= sampled;
      end
      rsp_valid_q <= read_done;
    end
  end

  always_comb begin
    req_ready = 1'b0;
    bus_t     = 1'b1;
    wr_n      = 1'b1;
    rd_n      = 1'b1;
    unique case (state_q)
      StIdle:    req_ready = 1'b1;
      StWSetup:  bus_t     = 1'b0;
      StWStrobe: begin
        bus_t = 1'b0;
        wr_n  = 1'b0;
      end
      StWHold:   bus_t     = 1'b0;
      StRStrobe: rd_n      = 1'b0;
      StTurn:    req_ready = 1'b0;
      default:   req_ready = 1'b0;
    endcase
  end

  assign bus_i     = bus_i_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_bidir_bus_port.sv
// Self-checking bench for bidir_bus_port: per-cycle reference derived from transaction offsets.
module tb_bidir_bus_port;

  localparam int S  = 2;
  localparam int ST = 2;
  localparam int H  = 1;
  localparam int T  = 2;
`ifdef BIDIR_BUS_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int RL   = ST + SYNC;
  localparam int WLEN = 1 + S + ST + H + T;
  localparam int RLEN = 1 + RL + T;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] bus_i;
  logic       bus_t;
  logic [7:0] bus_o = 8'h00;
  logic       wr_n;
  logic       rd_n;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] last_wr = 8'h00;

  bidir_bus_port #(
    .WIDTH        (8),
    .SETUP_CLOCKS (S),
    .STROBE_CLOCKS(ST),
    .HOLD_CLOCKS  (H),
    .TURN_CLOCKS  (T)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_data (req_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .bus_i    (bus_i),
    .bus_t    (bus_t),
    .bus_o    (bus_o),
    .wr_n     (wr_n),
    .rd_n     (rd_n)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of run, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Packed as {req_ready, bus_t, wr_n, rd_n, rsp_valid, bus_i}.
  task automatic check_outputs(input string tag, input bit ready, input bit t, input bit wn,
                               input bit rn, input bit rv, input logic [7:0] bi);
    chk(tag, {3'b000, req_ready, bus_t, wr_n, rd_n, rsp_valid, bus_i},
        {3'b000, ready, t, wn, rn, rv, bi});
    chk({tag, "_contention"}, {14'h0, (~bus_t & ~rd_n), (~wr_n & bus_t)}, 16'h0000);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0;
      bus_o     = 8'($urandom);
      check_outputs("idle", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, last_wr);
      step();
    end
  endtask

  // Issues one request from an idle cycle and checks every cycle until idle again.
  task automatic txn(input bit wr, input logic [7:0] d, input bit fix_pin,
                     input logic [7:0] pin, input bit hold_valid, input int abort_k,
                     input string tag);
    logic [7:0] cap;
    int         len;
    cap = 8'h00;
    len = wr ? WLEN : RLEN;
    req_valid = 1'b1;
    req_write = wr;
    req_data  = d;
    bus_o     = fix_pin ? pin : 8'($urandom);
    check_outputs({tag, "_c0"}, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, last_wr);
    step();
    if (wr) last_wr = d;
    for (int k = 1; k < len; k++) begin
      bus_o = fix_pin ? pin : 8'($urandom);
      if (k == ST) cap = bus_o;
      req_valid = hold_valid ? 1'b1 : 1'($urandom);
      req_write = 1'($urandom);
      req_data  = 8'($urandom);
      if (wr) begin
        check_outputs(tag, 1'b0, !(k <= S + ST + H), !(k > S && k <= S + ST), 1'b1, 1'b0,
                      last_wr);
      end else begin
        check_outputs(tag, 1'b0, 1'b1, 1'b1, !(k <= RL), (k == RL + 1), last_wr);
        if (k == RL + 1) chk({tag, "_rsp_data"}, {8'h00, rsp_data}, {8'h00, cap});
      end
      if (k == abort_k) begin
        reset = 1'b1;
        step();
        reset     = 1'b0;
        req_valid = 1'b0;
        last_wr   = 8'h00;
        check_outputs({tag, "_abort"}, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        return;
      end
      step();
    end
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_rsp_data", {8'h00, rsp_data}, 16'h0000);
    idle(4);

    txn(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 0, "write_a5");
    idle(1);
    txn(1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 0, "read_3c");
    idle(2);

    txn(1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 0, "b2b_wr11");
    txn(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 0, "b2b_rd");
    txn(1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 0, "b2b_wr22");
    idle(2);

    txn(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, S + 1, "reset_mid_write");
    idle(2);

    for (int n = 0; n < 1000; n++) begin
      idle(int'($urandom_range(0, 3)));
      txn(1'($urandom), 8'($urandom), 1'b0, 8'h00, 1'($urandom), 0, "rand");
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
